// File: rtl/rns_dbg_pkg.sv
// Shared definitions for the debug dump path: FSM encodings, record space tags
// and the helper that sizes a packed {space, addr, data} record.
package rns_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_RF_SCAN = 3'd2,
        ST_MEM_RD  = 3'd3,
        ST_MEM_CAP = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } dump_state_t;

    localparam logic SPACE_RF  = 1'b0;
    localparam logic SPACE_MEM = 1'b1;
    localparam int   SPACE_W   = 1;

    function automatic int rec_width(input int addr_w, input int data_w);
        return SPACE_W + addr_w + data_w;
    endfunction

endpackage

// File: rtl/dump_out_reg.sv
// Single-entry valid/ready holding register. A load may only be issued when
// o_can_load is high, i.e. the slot is empty or is being drained this cycle.
module dump_out_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_can_load,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_can_load = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

endmodule

// File: rtl/state_dump_engine.sv
// Halts the core, then streams every register file entry followed by the
// (optionally non-zero) data memory words as {space, addr, data} records.
module state_dump_engine
    import rns_dbg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RF_AW     = 3,
    parameter int MEM_AW    = 16,
    parameter int SKIP_ZERO = 1,
    parameter int HALT_EN   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_halt_req,
    input  logic              i_halt_ack,
    output logic [RF_AW-1:0]  o_rf_rd_addr,
    input  logic [DATA_W-1:0] i_rf_rd_data,
    output logic              o_mem_rd_en,
    output logic [MEM_AW-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_space,
    output logic [MEM_AW-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [MEM_AW:0]   o_rec_count
);

    localparam int                 REC_W    = rec_width(MEM_AW, DATA_W);
    localparam logic [RF_AW-1:0]   RF_LAST  = '1;
    localparam logic [RF_AW-1:0]   RF_ONE   = RF_AW'(1);
    localparam logic [MEM_AW-1:0]  MEM_LAST = '1;
    localparam logic [MEM_AW-1:0]  MEM_ONE  = MEM_AW'(1);
    localparam logic [MEM_AW:0]    CNT_ONE  = (MEM_AW + 1)'(1);
    localparam logic [MEM_AW:0]    CNT_MAX  = '1;

    dump_state_t       r_state, w_state_next;
    logic [RF_AW-1:0]  r_rf_idx, w_rf_idx_next;
    logic [MEM_AW-1:0] r_mem_idx, w_mem_idx_next;
    logic              r_cap_hold, w_cap_hold_next;
    logic [DATA_W-1:0] r_cap_data, w_cap_data_next;
    logic [MEM_AW:0]   r_rec_count;

    logic              w_load;
    logic              w_can_load;
    logic              w_clr_count;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_skip;
    logic [DATA_W-1:0] w_mem_word;
    logic [REC_W-1:0]  w_load_rec;
    logic [REC_W-1:0]  w_out_rec;

    // A stalled memory word is replayed from the capture register; memory is read once.
    assign w_mem_word = r_cap_hold ? r_cap_data : i_mem_rd_data;
    assign w_skip     = (SKIP_ZERO != 0) && (w_mem_word == '0);
    assign w_accept   = w_out_valid && i_out_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_rf_idx    <= '0;
            r_mem_idx   <= '0;
            r_cap_hold  <= 1'b0;
            r_cap_data  <= '0;
            r_rec_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rf_idx   <= w_rf_idx_next;
            r_mem_idx  <= w_mem_idx_next;
            r_cap_hold <= w_cap_hold_next;
            r_cap_data <= w_cap_data_next;
            if (w_clr_count) begin
                r_rec_count <= '0;
            end else if (w_accept && (r_rec_count != CNT_MAX)) begin
                r_rec_count <= r_rec_count + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rf_idx_next   = r_rf_idx;
        w_mem_idx_next  = r_mem_idx;
        w_cap_hold_next = r_cap_hold;
        w_cap_data_next = r_cap_data;
        w_load          = 1'b0;
        w_clr_count     = 1'b0;
        w_load_rec      = {SPACE_RF, MEM_AW'(r_rf_idx), i_rf_rd_data};
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_clr_count     = 1'b1;
                    w_rf_idx_next   = '0;
                    w_mem_idx_next  = '0;
                    w_cap_hold_next = 1'b0;
                    w_state_next    = (HALT_EN != 0) ? ST_HALT : ST_RF_SCAN;
                end
            end
            ST_HALT: begin
                if (i_halt_ack) begin
                    w_state_next = ST_RF_SCAN;
                end
            end
            ST_RF_SCAN: begin
                if (w_can_load) begin
                    w_load        = 1'b1;
                    w_rf_idx_next = r_rf_idx + RF_ONE;
                    if (r_rf_idx == RF_LAST) begin
                        w_mem_idx_next = '0;
                        w_state_next   = ST_MEM_RD;
                    end
                end
            end
            ST_MEM_RD: begin
                w_state_next = ST_MEM_CAP;
            end
            ST_MEM_CAP: begin
                w_load_rec = {SPACE_MEM, r_mem_idx, w_mem_word};
                if (w_skip || w_can_load) begin
                    w_load          = !w_skip;
                    w_cap_hold_next = 1'b0;
                    if (r_mem_idx == MEM_LAST) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_mem_idx_next = r_mem_idx + MEM_ONE;
                        w_state_next   = ST_MEM_RD;
                    end
                end else begin
                    w_cap_hold_next = 1'b1;
                    w_cap_data_next = w_mem_word;
                end
            end
            ST_DRAIN: begin
                if (w_can_load) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    dump_out_reg #(
        .W (REC_W)
    ) u_out_reg (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_data     (w_load_rec),
        .o_can_load (w_can_load),
        .o_valid    (w_out_valid),
        .i_ready    (i_out_ready),
        .o_data     (w_out_rec)
    );

    assign {o_out_space, o_out_addr, o_out_data} = w_out_rec;
    assign o_out_valid   = w_out_valid;
    assign o_halt_req    = (HALT_EN != 0) && (r_state != ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_mem_rd_en   = (r_state == ST_MEM_RD);
    assign o_rf_rd_addr  = r_rf_idx;
    assign o_mem_rd_addr = r_mem_idx;
    assign o_rec_count   = r_rec_count;

endmodule

// File: tb/tb_state_dump_engine.sv
// Bench for state_dump_engine: a record-queue model built from the RF/memory
// contents at start, checked every cycle, plus hand-computed anchor values.
module tb_state_dump_engine;

    localparam int DW    = 8;
    localparam int RAW   = 3;
    localparam int MAW   = 9;
    localparam int MBW   = 4;
    localparam int RF_N  = 1 << RAW;
    localparam int MEM_N = 1 << MAW;
    localparam int MB_N  = 1 << MBW;
    localparam int RW    = 1 + MAW + DW;
    localparam int RWB   = 1 + MBW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic           a_start, a_halt_req, a_halt_ack, a_mem_rd_en, a_valid, a_ready;
    logic           a_space, a_busy, a_done;
    logic [RAW-1:0] a_rf_addr;
    logic [DW-1:0]  a_rf_data, a_mem_data, a_data;
    logic [MAW-1:0] a_mem_addr, a_addr;
    logic [MAW:0]   a_cnt;

    logic           b_start, b_halt_req, b_halt_ack, b_mem_rd_en, b_valid, b_ready;
    logic           b_space, b_busy, b_done;
    logic [RAW-1:0] b_rf_addr;
    logic [DW-1:0]  b_rf_data, b_mem_data, b_data;
    logic [MBW-1:0] b_mem_addr, b_addr;
    logic [MBW:0]   b_cnt;

    logic [DW-1:0] rf    [RF_N];
    logic [DW-1:0] mem_a [MEM_N];
    logic [DW-1:0] mem_b [MB_N];

    assign a_rf_data = rf[a_rf_addr];
    assign b_rf_data = rf[b_rf_addr];
    always @(posedge clk) if (a_mem_rd_en) a_mem_data <= mem_a[a_mem_addr];
    always @(posedge clk) if (b_mem_rd_en) b_mem_data <= mem_b[b_mem_addr];

    state_dump_engine #(
        .DATA_W(DW), .RF_AW(RAW), .MEM_AW(MAW), .SKIP_ZERO(1), .HALT_EN(1)
    ) dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(a_start),
        .o_halt_req(a_halt_req), .i_halt_ack(a_halt_ack),
        .o_rf_rd_addr(a_rf_addr), .i_rf_rd_data(a_rf_data),
        .o_mem_rd_en(a_mem_rd_en), .o_mem_rd_addr(a_mem_addr), .i_mem_rd_data(a_mem_data),
        .o_out_valid(a_valid), .i_out_ready(a_ready), .o_out_space(a_space),
        .o_out_addr(a_addr), .o_out_data(a_data),
        .o_busy(a_busy), .o_done(a_done), .o_rec_count(a_cnt)
    );

    state_dump_engine #(
        .DATA_W(DW), .RF_AW(RAW), .MEM_AW(MBW), .SKIP_ZERO(0), .HALT_EN(0)
    ) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(b_start),
        .o_halt_req(b_halt_req), .i_halt_ack(b_halt_ack),
        .o_rf_rd_addr(b_rf_addr), .i_rf_rd_data(b_rf_data),
        .o_mem_rd_en(b_mem_rd_en), .o_mem_rd_addr(b_mem_addr), .i_mem_rd_data(b_mem_data),
        .o_out_valid(b_valid), .i_out_ready(b_ready), .o_out_space(b_space),
        .o_out_addr(b_addr), .o_out_data(b_data),
        .o_busy(b_busy), .o_done(b_done), .o_rec_count(b_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ready pattern: 0 = always, 1 = one cycle in three, 2 = random
    int ready_mode = 0;
    initial begin
        int phase;
        phase = 0;
        a_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       a_ready = (phase == 0);
                2:       a_ready = ($urandom_range(0, 1) == 1);
                default: a_ready = 1'b1;
            endcase
            phase = (phase + 1) % 3;
        end
    end

    // Reference model and per-cycle compare for DUT A
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] a_log[$];
    int            a_log_cyc[$];
    int  cyc = 0, a_done_cnt = 0, a_done_cyc = 0, a_mem_acc = 0, exp_total = 0;
    bit  p_stall = 1'b0, p_done = 1'b0, ack_seen = 1'b0;
    logic [RW-1:0] p_rec;

    always @(negedge clk) begin
        logic [RW-1:0] rec;
        rec = {a_space, a_addr, a_data};
        cyc++;
        if (rst) begin
            exp_q.delete();
            p_stall  = 1'b0;
            p_done   = 1'b0;
            ack_seen = 1'b0;
        end else begin
            if (a_busy && !ack_seen) begin
                chk("pre_ack_out_valid", a_valid, 1'b0);
                chk("pre_ack_mem_rd_en", a_mem_rd_en, 1'b0);
            end
            if (p_stall) begin
                chk("stall_valid_held", a_valid, 1'b1);
                chk("stall_fields_held", rec, p_rec);
            end
            if (a_valid && a_ready) begin
                if (exp_q.size() == 0) chk("unexpected_record", rec, 0);
                else                   chk("record", rec, exp_q.pop_front());
                a_log.push_back(rec);
                a_log_cyc.push_back(cyc);
                if (a_space) a_mem_acc++;
            end
            if (a_done) begin
                chk("done_single_pulse", p_done, 1'b0);
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_rec_count", a_cnt, exp_total);
                a_done_cnt++;
                a_done_cyc = cyc;
            end
            if (a_start && !a_busy) begin
                exp_q.delete();
                for (int i = 0; i < RF_N; i++) exp_q.push_back({1'b0, MAW'(i), rf[i]});
                for (int a = 0; a < MEM_N; a++)
                    if (mem_a[a] != 0) exp_q.push_back({1'b1, MAW'(a), mem_a[a]});
                exp_total = exp_q.size();
                a_mem_acc = 0;
            end
            if (!a_busy) ack_seen = 1'b0;
            else if (a_halt_ack) ack_seen = 1'b1;
            p_stall = a_valid && !a_ready;
            p_rec   = rec;
            p_done  = a_done;
        end
    end

    logic [RWB-1:0] b_log[$];
    int b_done_cnt = 0;
    bit b_halt_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (b_valid && b_ready) b_log.push_back({b_space, b_addr, b_data});
            if (b_done) b_done_cnt++;
            if (b_halt_req) b_halt_seen = 1'b1;
        end
    end

    task automatic pulse_a_start();
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
    endtask

    task automatic wait_a_done(input int limit);
        int c0, n;
        c0 = a_done_cnt;
        n  = 0;
        while (a_done_cnt == c0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk("a_done_within_budget", (n < limit), 1'b1);
        #1;
    endtask

    task automatic run_dump_a(input int ack_delay, input bit extra_starts);
        a_halt_ack = 1'b0;
        pulse_a_start();
        chk("halt_req_while_waiting", a_halt_req, 1'b1);
        chk("busy_while_waiting", a_busy, 1'b1);
        for (int k = 0; k < ack_delay; k++) begin
            @(posedge clk); #1;
            a_start = extra_starts && (k % 5 == 2);
        end
        @(posedge clk); #1;
        a_start    = 1'b0;
        a_halt_ack = 1'b1;
        repeat (12) @(posedge clk);
        #1 a_halt_ack = 1'b0;
        wait_a_done(20000);
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_valid"}, a_valid, 1'b0);
        chk({tag, "_halt_req"}, a_halt_req, 1'b0);
        chk({tag, "_busy"}, a_busy, 1'b0);
        chk({tag, "_done"}, a_done, 1'b0);
        chk({tag, "_mem_rd_en"}, a_mem_rd_en, 1'b0);
        chk({tag, "_rec_count"}, a_cnt, 0);
        chk({tag, "_record"}, {a_space, a_addr, a_data, a_rf_addr, a_mem_addr}, 0);
    endtask

    initial begin
        int base, n;
        logic [RW-1:0]  e;
        logic [RWB-1:0] eb;
        rst = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_halt_ack = 1'b0; b_halt_ack = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < RF_N; i++) rf[i] = 8'(11 * i);
        for (int a = 0; a < MEM_N; a++) mem_a[a] = 8'd0;
        for (int a = 0; a < MB_N; a++) mem_b[a] = (a % 3 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        #1 rst = 1'b1;
        #1 check_a_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // 1: empty memory, RF only, one record per cycle
        base = a_log.size();
        run_dump_a(3, 1'b0);
        chk("t1_rec_count", a_cnt, 8);
        chk("t1_log_size", a_log.size() - base, 8);
        for (int k = 0; k < 8; k++) begin
            e = {1'b0, MAW'(k), 8'(11 * k)};
            chk("t1_rf_record", a_log[base + k], e);
            chk("t1_back_to_back", a_log_cyc[base + k] - a_log_cyc[base], k);
        end
        chk("t1_idle_after_done", a_busy, 1'b0);

        // 2: three sparse memory words
        mem_a[5] = 8'd9; mem_a[300] = 8'd200; mem_a[MEM_N-1] = 8'd1;
        base = a_log.size();
        run_dump_a(2, 1'b0);
        chk("t2_rec_count", a_cnt, 11);
        e = {1'b1, 9'd5, 8'd9};     chk("t2_mem_rec0", a_log[base + 8], e);
        e = {1'b1, 9'd300, 8'd200}; chk("t2_mem_rec1", a_log[base + 9], e);
        e = {1'b1, 9'd511, 8'd1};   chk("t2_mem_rec2", a_log[base + 10], e);
        chk("t2_done_after_last", a_done_cyc - a_log_cyc[base + 10], 1);

        // 3: stalling sink, random contents
        ready_mode = 1;
        for (int i = 0; i < RF_N; i++) rf[i] = 8'($urandom);
        for (int a = 0; a < MEM_N; a++)
            mem_a[a] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        run_dump_a(3, 1'b0);

        // 4: late halt_ack with start pulses while busy
        ready_mode = 2;
        for (int a = 0; a < MEM_N; a++)
            mem_a[a] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'd0;
        run_dump_a(20, 1'b1);

        // 5: reset in the middle of the memory phase, then a full dump
        a_halt_ack = 1'b0;
        pulse_a_start();
        repeat (2) @(posedge clk);
        #1 a_halt_ack = 1'b1;
        n = 0;
        while (a_mem_acc < 5 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("t5_reached_fifth_mem", (n < 20000), 1'b1);
        #2 rst = 1'b1;
        #1 check_a_zero("midreset");
        a_halt_ack = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        ready_mode = 0;
        base = a_log.size();
        run_dump_a(1, 1'b0);
        e = {1'b0, MAW'(0), rf[0]};
        chk("t5_restart_rf0", a_log[base], e);

        // 6: no zero skipping, small memory, no halt handshake
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        n = 0;
        while (b_done_cnt == 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("t6_done_within_budget", (n < 2000), 1'b1);
        #1;
        chk("t6_log_size", b_log.size(), RF_N + MB_N);
        chk("t6_rec_count", b_cnt, RF_N + MB_N);
        chk("t6_no_halt_req", b_halt_seen, 1'b0);
        for (int k = 0; k < RF_N + MB_N && k < b_log.size(); k++) begin
            if (k < RF_N) eb = {1'b0, MBW'(k), rf[k]};
            else          eb = {1'b1, MBW'(k - RF_N), mem_b[k - RF_N]};
            chk("t6_record", b_log[k], eb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/state_dump_engine.md
Name: state_dump_engine

Overview:
Hardware successor to the bench-side end-of-run dump of register file and data memory. On a start pulse it halts the core, then walks the register file and the data memory. It streams (space, address, data) records over a valid/ready port to a debug UART/trace sink. Width, depths, memory read latency and zero-skipping are parameters, so the same block serves the 8-bit RNS core and wider variants.

Parameters:
DATA_W, 8, register and memory word width
RF_AW, 3, register file address width (RF depth = 2**RF_AW)
MEM_AW, 16, data memory address width (scan covers 0 .. 2**MEM_AW-1)
SKIP_ZERO, 1, 1: memory words equal to 0 are not emitted; register file entries are always emitted
HALT_EN, 1, 1: request and await core halt before scanning; 0: halt_req tied 0, no wait

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a dump; ignored while busy
halt_req  out  1  asks core to freeze pipeline; high from HALT until DONE
halt_ack  in  1  core frozen
rf_rd_addr  out  RF_AW  register file read address (combinational read port)
rf_rd_data  in  DATA_W  register file read data, same cycle
mem_rd_en  out  1  data memory read strobe
mem_rd_addr  out  MEM_AW  data memory read address
mem_rd_data  in  DATA_W  valid exactly one cycle after mem_rd_en
out_valid  out  1  record valid
out_ready  in  1  sink accepts record
out_space  out  1  0 = register file, 1 = data memory
out_addr  out  MEM_AW  entry address; RF addresses zero-extended
out_data  out  DATA_W  entry value
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse when the final record is accepted
rec_count  out  MEM_AW+1  records emitted in last/current dump; cleared on accepted start

Behaviour:
- Reset, async: state IDLE; all outputs 0; counters 0; output register empty.
- FSM states: IDLE, HALT, RF_SCAN, MEM_RD, MEM_CAP, DRAIN, DONE.
- IDLE: start=1 -> busy=1, rec_count=0, next HALT. With HALT_EN=0, next RF_SCAN.
- HALT: halt_req=1; wait for halt_ack=1, then go to RF_SCAN. No timeout.
- RF_SCAN: rf_rd_addr = RF index.
  - When the output register is empty, or is being accepted this cycle, load {0, index, rf_rd_data} and increment the index.
  - Index wrap from 2**RF_AW-1 -> MEM_RD with memory index 0.
  - Sustains 1 record/cycle with out_ready held high.
- MEM_RD: assert mem_rd_en for one cycle with mem_rd_addr = memory index; next MEM_CAP.
- MEM_CAP: mem_rd_data is valid this cycle.
  - If SKIP_ZERO=1 and data == 0: discard the word.
  - Otherwise the word must be loaded into the output register. If the register cannot take it, stay in MEM_CAP holding a captured copy; memory is not re-read.
  - After discard or load: if index == 2**MEM_AW-1, go to DRAIN; else increment the index and go to MEM_RD.
  - Peak rate 1 record per 2 cycles.
- DRAIN: wait until the output register is empty or being accepted -> DONE.
- DONE: done=1 for one cycle; busy and halt_req drop next cycle; state returns to IDLE.
- Output handshake:
  - A record transfers when out_valid and out_ready are both high.
  - While out_valid=1 and out_ready=0, out_space, out_addr and out_data are held stable.
  - out_valid never drops without acceptance, except on reset.
- rec_count increments on every accepted record, saturating at all-ones.
- Empty memory with SKIP_ZERO=1: exactly 2**RF_AW records, then done.
- start while busy: ignored, with no effect on counters.
- Reset mid-dump: immediate IDLE; halt_req and out_valid drop asynchronously; any partial record is lost.
- halt_ack dropping mid-scan: ignored; the scan continues.

Decomposition:
- Shared package rns_dbg_pkg:
  - state enum encodings
  - SPACE_RF=0 and SPACE_MEM=1 constants
  - record field widths as derived localparams
- One sub-module dump_out_reg: single-entry valid/ready holding register with load/accept. It is reused by the trace port.

Test Plan:
- Reset RF to {0,11,22,33,44,55,66,77}, memory zero, out_ready=1, pulse start -> after halt_ack, 8 records (0,i,11*i) on consecutive cycles; done; rec_count=8.
- Memory holds [5]=9, [300]=200, [65535]=1 -> 3 MEM records after the RF records, in address order; rec_count=11; done follows the [65535] record.
- out_ready toggling 1-of-3 cycles during RF and MEM scans -> no record lost or duplicated; fields stable while stalled.
- SKIP_ZERO=0, MEM_AW=4 -> 8 RF + 16 MEM records, zero words included.
- halt_ack delayed 20 cycles -> no rf/mem access before ack; start pulses during busy ignored.
- Assert reset at the 5th MEM record -> all outputs 0 immediately; a new start after reset produces a full dump from RF index 0.
